// File: rtl/qeciphy_pkg.sv
// Shared definitions for the QECi PHY channel encoder/decoder pair.
// Control beat layout: {CTRL_MARKER, code, ~code, 8'h00}.
package qeciphy_pkg;

   localparam logic [7:0] CTRL_MARKER = 8'hBC;

   typedef enum logic [7:0] {
      CODE_IDLE   = 8'h00,
      CODE_RX_RDY = 8'h01,
      CODE_PD_REQ = 8'h02,
      CODE_PD_ACK = 8'h03
   } ctrl_code_t;

   typedef enum logic [1:0] {
      ST_ALIGN = 2'd0,
      ST_LO    = 2'd1,
      ST_HI    = 2'd2
   } dec_state_t;

endpackage

// File: rtl/qeciphy_rx_ctrl_decode.sv
// Combinational classifier for a 32-bit GT beat: flags a well-formed control
// beat carrying a known code and exposes the raw code byte.
module qeciphy_rx_ctrl_decode
   import qeciphy_pkg::*;
(
   input  logic [31:0] beat,
   output logic        is_valid_ctrl,
   output logic [7:0]  code
);

   logic known;

   always_comb begin
      code  = beat[23:16];
      known = (beat[23:16] <= CODE_PD_ACK);
      is_valid_ctrl = (beat[31:24] == CTRL_MARKER) &&
                      (beat[15:8] == ~beat[23:16]) &&
                      (beat[7:0] == 8'h00) && known;
   end

endmodule

// File: rtl/qeciphy_rx_channeldecoder.sv
// RX channel decoder: framing lock, two-beat word reassembly and control decode.
// Optional macro QECIPHY_RX_DECODER_STATS_EN adds the o_frame_count output.
//
// state    | meaning
// ST_ALIGN | hunting for LOCK_COUNT consecutive valid control beats
// ST_LO    | locked, expecting low data beat or a control beat
// ST_HI    | locked, low half held, expecting the high data beat
module qeciphy_rx_channeldecoder
   import qeciphy_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 8,
   parameter int unsigned ERR_THRESH = 4
) (
   input  logic        rx_clk,
   input  logic        rx_rst,
   input  logic [31:0] i_gt_rx_data,
   input  logic        i_gt_rx_ctrl,
   input  logic        i_gt_rx_valid,
   output logic [63:0] o_data,
   output logic        o_valid,
   output logic        o_locked,
   output logic        o_remote_rx_rdy,
   output logic        o_pd_req,
   output logic        o_pd_ack,
`ifdef QECIPHY_RX_DECODER_STATS_EN
   output logic [31:0] o_frame_count,
`endif
   output logic [7:0]  o_err_count
);

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
   localparam logic [3:0] ERR_LAST  = 4'(ERR_THRESH - 1);

   dec_state_t  state, state_nxt;
   logic [7:0]  lock_cnt, lock_cnt_nxt;
   logic [3:0]  err_run, err_run_nxt;
   logic [31:0] low, low_nxt;
   logic [63:0] data_nxt;
   logic [7:0]  err_cnt_nxt;
   logic        valid_nxt, locked_nxt, rdy_nxt, pd_req_nxt, pd_ack_nxt;
   logic        frame_err, decode_en;
   logic        is_valid_ctrl;
   logic [7:0]  code;
`ifdef QECIPHY_RX_DECODER_STATS_EN
   logic [31:0] frame_nxt;
`endif

   qeciphy_rx_ctrl_decode u_ctrl_decode (
      .beat          (i_gt_rx_data),
      .is_valid_ctrl (is_valid_ctrl),
      .code          (code)
   );

   always_comb begin
      state_nxt    = state;
      lock_cnt_nxt = lock_cnt;
      err_run_nxt  = err_run;
      low_nxt      = low;
      data_nxt     = o_data;
      err_cnt_nxt  = o_err_count;
      locked_nxt   = o_locked;
      rdy_nxt      = o_remote_rx_rdy;
      valid_nxt    = 1'b0;
      pd_req_nxt   = 1'b0;
      pd_ack_nxt   = 1'b0;
      frame_err    = 1'b0;
      decode_en    = 1'b0;
`ifdef QECIPHY_RX_DECODER_STATS_EN
      frame_nxt    = o_frame_count;
`endif

      if (i_gt_rx_valid) begin
         case (state)
            ST_ALIGN: begin
               if (i_gt_rx_ctrl && is_valid_ctrl) begin
                  if (lock_cnt == LOCK_LAST) begin
                     state_nxt    = ST_LO;
                     locked_nxt   = 1'b1;
                     lock_cnt_nxt = 8'd0;
                  end else begin
                     lock_cnt_nxt = lock_cnt + 8'd1;
                  end
               end else begin
                  lock_cnt_nxt = 8'd0;
               end
            end
            ST_LO: begin
               if (!i_gt_rx_ctrl) begin
                  low_nxt     = i_gt_rx_data;
                  state_nxt   = ST_HI;
                  err_run_nxt = 4'd0;
               end else if (is_valid_ctrl) begin
                  decode_en   = 1'b1;
                  err_run_nxt = 4'd0;
               end else begin
                  frame_err = 1'b1;
               end
            end
            ST_HI: begin
               state_nxt = ST_LO;
               if (!i_gt_rx_ctrl) begin
                  data_nxt    = {i_gt_rx_data, low};
                  valid_nxt   = 1'b1;
                  err_run_nxt = 4'd0;
`ifdef QECIPHY_RX_DECODER_STATS_EN
                  frame_nxt   = o_frame_count + 32'd1;
`endif
               end else begin
                  // Truncated word: drop the low half but still honour the control beat.
                  frame_err = 1'b1;
                  decode_en = is_valid_ctrl;
               end
            end
            default: state_nxt = ST_ALIGN;
         endcase
      end

      if (decode_en) begin
         case (code)
            CODE_RX_RDY: rdy_nxt    = 1'b1;
            CODE_PD_REQ: pd_req_nxt = 1'b1;
            CODE_PD_ACK: pd_ack_nxt = 1'b1;
            default: ;
         endcase
      end

      if (frame_err) begin
         if (o_err_count != 8'hFF) err_cnt_nxt = o_err_count + 8'd1;
         err_run_nxt = err_run + 4'd1;
         if (err_run == ERR_LAST) begin
            state_nxt    = ST_ALIGN;
            locked_nxt   = 1'b0;
            rdy_nxt      = 1'b0;
            lock_cnt_nxt = 8'd0;
            err_run_nxt  = 4'd0;
`ifdef QECIPHY_RX_DECODER_STATS_EN
            frame_nxt    = 32'd0;
`endif
         end
      end
   end

   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         state           <= ST_ALIGN;
         lock_cnt        <= 8'd0;
         err_run         <= 4'd0;
         low             <= 32'd0;
         o_data          <= 64'd0;
         o_valid         <= 1'b0;
         o_locked        <= 1'b0;
         o_remote_rx_rdy <= 1'b0;
         o_pd_req        <= 1'b0;
         o_pd_ack        <= 1'b0;
         o_err_count     <= 8'd0;
`ifdef QECIPHY_RX_DECODER_STATS_EN
         o_frame_count   <= 32'd0;
`endif
      end else begin
         state           <= state_nxt;
         lock_cnt        <= lock_cnt_nxt;
         err_run         <= err_run_nxt;
         low             <= low_nxt;
         o_data          <= data_nxt;
         o_valid         <= valid_nxt;
         o_locked        <= locked_nxt;
         o_remote_rx_rdy <= rdy_nxt;
         o_pd_req        <= pd_req_nxt;
         o_pd_ack        <= pd_ack_nxt;
         o_err_count     <= err_cnt_nxt;
`ifdef QECIPHY_RX_DECODER_STATS_EN
         o_frame_count   <= frame_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_qeciphy_rx_channeldecoder.sv
// Bench for qeciphy_rx_channeldecoder: directed scenarios with literal
// expectations plus random beats checked against a behavioural model.
module tb_qeciphy_rx_channeldecoder;

   localparam int LOCK_COUNT = 8;
   localparam int ERR_THRESH = 4;

   logic        rx_clk = 1'b0;
   logic        rx_rst = 1'b1;
   logic [31:0] i_gt_rx_data = '0;
   logic        i_gt_rx_ctrl = 1'b0;
   logic        i_gt_rx_valid = 1'b0;
   logic [63:0] o_data;
   logic        o_valid, o_locked, o_remote_rx_rdy, o_pd_req, o_pd_ack;
   logic [7:0]  o_err_count;
`ifdef QECIPHY_RX_DECODER_STATS_EN
   logic [31:0] o_frame_count;
`endif

   qeciphy_rx_channeldecoder #(.LOCK_COUNT(LOCK_COUNT), .ERR_THRESH(ERR_THRESH)) dut (
      .rx_clk          (rx_clk),
      .rx_rst          (rx_rst),
      .i_gt_rx_data    (i_gt_rx_data),
      .i_gt_rx_ctrl    (i_gt_rx_ctrl),
      .i_gt_rx_valid   (i_gt_rx_valid),
      .o_data          (o_data),
      .o_valid         (o_valid),
      .o_locked        (o_locked),
      .o_remote_rx_rdy (o_remote_rx_rdy),
      .o_pd_req        (o_pd_req),
      .o_pd_ack        (o_pd_ack),
`ifdef QECIPHY_RX_DECODER_STATS_EN
      .o_frame_count   (o_frame_count),
`endif
      .o_err_count     (o_err_count)
   );

   always #5 rx_clk = ~rx_clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: lock flag, run of good control beats, optional held low half.
   bit          m_locked, m_rdy, m_have_low;
   int          m_run, m_err_run, m_err_cnt;
   logic [31:0] m_low, m_frames;
   logic [63:0] e_data;
   bit          e_valid, e_pd_req, e_pd_ack;

   function automatic bit ctrl_ok(logic [31:0] d);
      logic [7:0] c;
      c = d[23:16];
      return d[31:24] == 8'hBC && d[7:0] == 8'h00 && (d[15:8] ^ c) == 8'hFF && c < 8'd4;
   endfunction

   function automatic logic [31:0] mk_ctrl(logic [7:0] c);
      return {8'hBC, c, ~c, 8'h00};
   endfunction

   task automatic model_step(bit rst, bit v, bit c, logic [31:0] d);
      bit good, ferr;
      e_valid = 0; e_pd_req = 0; e_pd_ack = 0;
      if (rst) begin
         m_locked = 0; m_rdy = 0; m_have_low = 0; m_run = 0; m_err_run = 0;
         m_err_cnt = 0; m_low = 0; m_frames = 0; e_data = 0;
         return;
      end
      if (!v) return;
      good = c && ctrl_ok(d);
      if (!m_locked) begin
         m_run = good ? m_run + 1 : 0;
         if (m_run == LOCK_COUNT) begin
            m_locked = 1; m_run = 0; m_have_low = 0;
         end
         return;
      end
      ferr = 0;
      if (!c) begin
         if (m_have_low) begin
            e_data = {d, m_low}; e_valid = 1; m_have_low = 0; m_frames++;
         end else begin
            m_low = d; m_have_low = 1;
         end
         m_err_run = 0;
      end else begin
         ferr = m_have_low || !good;
         m_have_low = 0;
         if (good) begin
            if (d[23:16] == 8'h01) m_rdy = 1;
            if (d[23:16] == 8'h02) e_pd_req = 1;
            if (d[23:16] == 8'h03) e_pd_ack = 1;
         end
         if (!ferr) m_err_run = 0;
      end
      if (ferr) begin
         if (m_err_cnt < 255) m_err_cnt++;
         m_err_run++;
         if (m_err_run == ERR_THRESH) begin
            m_locked = 0; m_rdy = 0; m_err_run = 0; m_run = 0; m_frames = 0;
         end
      end
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one beat (or reset), advance a cycle, compare every output with the model.
   task automatic cycle(bit rst, bit v, bit c, logic [31:0] d);
      rx_rst = rst; i_gt_rx_valid = v; i_gt_rx_ctrl = c; i_gt_rx_data = d;
      model_step(rst, v, c, d);
      @(posedge rx_clk);
      #1;
      chk("o_valid", 64'(o_valid), 64'(e_valid));
      chk("o_data", o_data, e_data);
      chk("o_locked", 64'(o_locked), 64'(m_locked));
      chk("o_remote_rx_rdy", 64'(o_remote_rx_rdy), 64'(m_rdy));
      chk("o_pd_req", 64'(o_pd_req), 64'(e_pd_req));
      chk("o_pd_ack", 64'(o_pd_ack), 64'(e_pd_ack));
      chk("o_err_count", 64'(o_err_count), 64'(m_err_cnt));
`ifdef QECIPHY_RX_DECODER_STATS_EN
      chk("o_frame_count", 64'(o_frame_count), 64'(m_frames));
`endif
      rx_rst = 0;
   endtask

   task automatic beat_ctrl(logic [7:0] c);
      cycle(0, 1, 1, mk_ctrl(c));
   endtask

   task automatic beat_data(logic [31:0] d);
      cycle(0, 1, 0, d);
   endtask

   task automatic lock_up();
      for (int i = 0; i < LOCK_COUNT; i++) beat_ctrl(8'h00);
   endtask

   initial begin
      int sel, bias;
      logic [31:0] rd;

      cycle(1, 0, 0, 0);
      chk("reset_all_zero", {o_data[31:0], 24'(o_err_count), o_valid, o_locked,
                             o_remote_rx_rdy, o_pd_req, o_pd_ack, 3'b0}, 64'h0);

      // Lock acquisition
      for (int i = 0; i < 7; i++) beat_ctrl(8'h00);
      beat_data(32'hDEADBEEF);
      chk("lock_7_then_data", 64'(o_locked), 64'h0);
      for (int i = 0; i < 7; i++) beat_ctrl(8'h00);
      chk("lock_after_7", 64'(o_locked), 64'h0);
      beat_ctrl(8'h00);
      chk("lock_after_8", 64'(o_locked), 64'h1);

      // Data reassembly
      beat_data(32'h11111111);
      chk("no_valid_low", 64'(o_valid), 64'h0);
      beat_data(32'h22222222);
      chk("word_valid", 64'(o_valid), 64'h1);
      chk("word_data", o_data, 64'h22222222_11111111);
      beat_data(32'h11111111);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, $urandom);
      beat_data(32'h22222222);
      chk("word_stall_valid", 64'(o_valid), 64'h1);
      chk("word_stall_data", o_data, 64'h22222222_11111111);

      // Control decode
      cycle(0, 1, 1, 32'hBC01FE00);
      chk("rx_rdy_set", 64'(o_remote_rx_rdy), 64'h1);
      beat_ctrl(8'h00);
      beat_data(32'h0);
      chk("rx_rdy_held", 64'(o_remote_rx_rdy), 64'h1);
      beat_data(32'h0);
      cycle(0, 1, 1, 32'hBC02FD00);
      chk("pd_req_pulse", 64'(o_pd_req), 64'h1);
      cycle(0, 0, 0, 0);
      chk("pd_req_one_cycle", 64'(o_pd_req), 64'h0);

      // Truncation
      beat_data(32'hAAAA5555);
      beat_ctrl(8'h03);
      chk("trunc_no_valid", 64'(o_valid), 64'h0);
      chk("trunc_pd_ack", 64'(o_pd_ack), 64'h1);
      chk("trunc_err_count", 64'(o_err_count), 64'h1);
      beat_data(32'h33333333);
      beat_data(32'h44444444);
      chk("trunc_back_in_lo", o_data, 64'h44444444_33333333);

      // Loss of lock and relock
      cycle(1, 0, 0, 0);
      lock_up();
      beat_ctrl(8'h01);
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, 32'hBC010000);
      chk("lol_locked", 64'(o_locked), 64'h0);
      chk("lol_rdy", 64'(o_remote_rx_rdy), 64'h0);
      chk("lol_err_count", 64'(o_err_count), 64'h4);
      for (int i = 0; i < 7; i++) beat_ctrl(8'h01);
      chk("relock_after_7", 64'(o_locked), 64'h0);
      beat_ctrl(8'h01);
      chk("relock_after_8", 64'(o_locked), 64'h1);

      // Reset mid-word
      beat_data(32'h55555555);
      cycle(1, 0, 0, 0);
      chk("rst_mid_locked", 64'(o_locked), 64'h0);
      chk("rst_mid_data", o_data, 64'h0);
      beat_data(32'h66666666);
      chk("rst_mid_no_valid", 64'(o_valid), 64'h0);
      lock_up();
      beat_data(32'h77777777);
      beat_data(32'h88888888);
      chk("rst_mid_fresh_word", o_data, 64'h88888888_77777777);

      // Randomized traffic with alternating bias toward lock acquisition
      bias = 0;
      for (int n = 0; n < 4000; n++) begin
         if (n % 64 == 0) bias = $urandom_range(0, 2);
         if ($urandom_range(0, 599) == 0) begin
            cycle(1, 0, 0, 0);
            continue;
         end
         sel = $urandom_range(0, 99);
         rd = $urandom;
         if ($urandom_range(0, 4) == 0) cycle(0, 0, $urandom_range(0, 1), rd);
         else if (bias == 0 && sel < 90) beat_ctrl(8'($urandom_range(0, 3)));
         else if (sel < 55) beat_data(rd);
         else if (sel < 90) beat_ctrl(8'($urandom_range(0, 3)));
         else if (sel < 95) cycle(0, 1, 1, {8'hBC, rd[23:16], rd[15:8], 8'h00});
         else cycle(0, 1, 1, rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
